// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
// Shared types and constants for the multi-channel tick generator.
//   tick_mode_e       : PERIODIC (re-arms after every tick) / ONESHOT (one tick, then idle)
//   ch_state_e        : per-channel FSM state (IDLE = not counting, RUN = counting)
//   TICK_DEFAULT_RATE : rate loaded at reset (1 Hz tick from a 50 MHz clock)
//   cfg_sel_width()   : width of the channel-select field, never below 1 bit
// -----------------------------------------------------------------------------
package tick_pkg;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } tick_mode_e;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    localparam int unsigned TICK_DEFAULT_RATE = 49_999_999;

    function automatic int unsigned cfg_sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One independent rate-divider channel: counter, IDLE/RUN FSM, shadow rate/mode
// registers for glitch-free reprogramming, and a registered one-cycle tick.
// Ports:
//   i_clk, i_rstn           : clock, synchronous active-low reset
//   i_cfg_we                : config write aimed at this channel
//   i_cfg_rate, i_cfg_mode  : rate (period = rate+1 clocks) and mode to write
//   i_start, i_stop         : start/restart and stop pulses (stop wins)
//   o_tick                  : one-cycle tick on every counter wrap
//   o_busy                  : channel is counting
//   o_pending               : shadow rate/mode waiting for the next wrap
// -----------------------------------------------------------------------------
module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned      WIDTH        = 28,
    parameter logic [WIDTH-1:0] DEFAULT_RATE = WIDTH'(TICK_DEFAULT_RATE)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_rate,
    input  tick_mode_e       i_cfg_mode,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_pending
);

    ch_state_e        r_state,    w_state_nx;
    logic [WIDTH-1:0] r_counter,  w_counter_nx;
    logic [WIDTH-1:0] r_act_rate, w_act_rate_nx;
    tick_mode_e       r_act_mode, w_act_mode_nx;
    logic [WIDTH-1:0] r_sh_rate,  w_sh_rate_nx;
    tick_mode_e       r_sh_mode,  w_sh_mode_nx;
    logic             r_pending,  w_pending_nx;
    logic             r_tick,     w_tick_nx;
    logic             w_wrap;

    // Counter never exceeds the active rate, so equality is the wrap condition.
    assign w_wrap = (r_state == CH_RUN) && (r_counter == r_act_rate);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= CH_IDLE;
            r_counter  <= '0;
            r_act_rate <= DEFAULT_RATE;
            r_act_mode <= PERIODIC;
            r_sh_rate  <= DEFAULT_RATE;
            r_sh_mode  <= PERIODIC;
            r_pending  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_counter  <= w_counter_nx;
            r_act_rate <= w_act_rate_nx;
            r_act_mode <= w_act_mode_nx;
            r_sh_rate  <= w_sh_rate_nx;
            r_sh_mode  <= w_sh_mode_nx;
            r_pending  <= w_pending_nx;
            r_tick     <= w_tick_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_counter_nx  = r_counter;
        w_act_rate_nx = r_act_rate;
        w_act_mode_nx = r_act_mode;
        w_sh_rate_nx  = r_sh_rate;
        w_sh_mode_nx  = r_sh_mode;
        w_pending_nx  = r_pending;
        w_tick_nx     = 1'b0;

        // An idle channel takes the new setting immediately; a running one
        // parks it in the shadow so the period in progress is not disturbed.
        if (i_cfg_we) begin
            if (r_state == CH_IDLE) begin
                w_act_rate_nx = i_cfg_rate;
                w_act_mode_nx = i_cfg_mode;
            end else begin
                w_sh_rate_nx = i_cfg_rate;
                w_sh_mode_nx = i_cfg_mode;
                w_pending_nx = 1'b1;
            end
        end

        // Every period boundary (wrap, restart, stop) is a safe point to
        // promote the shadow, including a write arriving on that same edge.
        if ((i_start || i_stop || w_wrap) && w_pending_nx) begin
            w_act_rate_nx = w_sh_rate_nx;
            w_act_mode_nx = w_sh_mode_nx;
            w_pending_nx  = 1'b0;
        end

        if (i_stop) begin
            w_state_nx   = CH_IDLE;
            w_counter_nx = '0;
        end else if (i_start) begin
            w_state_nx   = CH_RUN;
            w_counter_nx = '0;
        end else if (r_state == CH_RUN) begin
            if (w_wrap) begin
                w_counter_nx = '0;
                w_tick_nx    = 1'b1;
                // The mode of the period that just ended decides re-arming.
                if (r_act_mode == ONESHOT) begin
                    w_state_nx = CH_IDLE;
                end
            end else begin
                w_counter_nx = r_counter + WIDTH'(1);
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_busy    = (r_state == CH_RUN);
    assign o_pending = r_pending;

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// Multi-channel rate divider: CHANNELS independent tick_channel instances sharing
// one configuration write port.
// Ports:
//   clock_in    : sole clock, rising edge
//   resetn      : synchronous active-low reset
//   cfg_valid   : config write strobe (always accepted)
//   cfg_channel : target channel; values >= CHANNELS are ignored
//   cfg_rate    : new rate, period = cfg_rate+1 clocks
//   cfg_mode    : 0 = periodic, 1 = one-shot
//   start, stop : per-channel start/restart and stop pulses
//   tick        : per-channel registered one-cycle tick
//   busy        : per-channel counting flag
//   pending     : per-channel shadow-waiting flag
// -----------------------------------------------------------------------------
module tick_generator
    import tick_pkg::*;
#(
    parameter int unsigned      CHANNELS     = 4,
    parameter int unsigned      WIDTH        = 28,
    parameter logic [WIDTH-1:0] DEFAULT_RATE = WIDTH'(TICK_DEFAULT_RATE),
    localparam int unsigned     SEL_W        = cfg_sel_width(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                resetn,
    input  logic                cfg_valid,
    input  logic [SEL_W-1:0]    cfg_channel,
    input  logic [WIDTH-1:0]    cfg_rate,
    input  logic                cfg_mode,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] pending
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic w_cfg_we;

        // Out-of-range selects match no channel, so the write is dropped.
        assign w_cfg_we = cfg_valid && (32'(cfg_channel) == 32'(gi));

        tick_channel #(
            .WIDTH        (WIDTH),
            .DEFAULT_RATE (DEFAULT_RATE)
        ) u_channel (
            .i_clk      (clock_in),
            .i_rstn     (resetn),
            .i_cfg_we   (w_cfg_we),
            .i_cfg_rate (cfg_rate),
            .i_cfg_mode (tick_mode_e'(cfg_mode)),
            .i_start    (start[gi]),
            .i_stop     (stop[gi]),
            .o_tick     (tick[gi]),
            .o_busy     (busy[gi]),
            .o_pending  (pending[gi])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_generator
// Directed and randomized checks of tick_generator against a schedule-based
// reference model (absolute edge numbers of upcoming ticks).
// -----------------------------------------------------------------------------
module tb_tick_generator;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int DEF = 12;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn      = 1'b0;
    logic          cfg_valid   = 1'b0;
    logic [1:0]    cfg_channel = '0;
    logic [W-1:0]  cfg_rate    = '0;
    logic          cfg_mode    = 1'b0;
    logic [CH-1:0] start       = '0;
    logic [CH-1:0] stop        = '0;
    logic [CH-1:0] tick, busy, pending;

    logic          d3_cfg_valid   = 1'b0;
    logic [1:0]    d3_cfg_channel = '0;
    logic [W-1:0]  d3_cfg_rate    = '0;
    logic          d3_cfg_mode    = 1'b0;
    logic [2:0]    d3_start       = '0;
    logic [2:0]    d3_stop        = '0;
    logic [2:0]    d3_tick, d3_busy, d3_pending;

    tick_generator #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_RATE(W'(DEF))) u_dut (
        .clock_in    (clk),
        .resetn      (resetn),
        .cfg_valid   (cfg_valid),
        .cfg_channel (cfg_channel),
        .cfg_rate    (cfg_rate),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .busy        (busy),
        .pending     (pending)
    );

    // Three-channel instance: select value 3 is representable but out of range.
    tick_generator #(.CHANNELS(3), .WIDTH(W), .DEFAULT_RATE(W'(DEF))) u_dut3 (
        .clock_in    (clk),
        .resetn      (resetn),
        .cfg_valid   (d3_cfg_valid),
        .cfg_channel (d3_cfg_channel),
        .cfg_rate    (d3_cfg_rate),
        .cfg_mode    (d3_cfg_mode),
        .start       (d3_start),
        .stop        (d3_stop),
        .tick        (d3_tick),
        .busy        (d3_busy),
        .pending     (d3_pending)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: rate/mode plus the absolute edge number of the next tick.
    int  n = 0;
    int  m_rate[CH], m_sh_rate[CH], m_next[CH];
    bit  m_mode[CH], m_sh_mode[CH], m_busy[CH], m_pend[CH];
    logic [CH-1:0] e_tick, e_busy, e_pend;
    int  t_cnt[CH], t_first[CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        n++;
        for (int c = 0; c < CH; c++) begin
            bit old_mode;
            e_tick[c] = 1'b0;
            if (!resetn) begin
                m_rate[c] = DEF; m_sh_rate[c] = DEF;
                m_mode[c] = 0;   m_sh_mode[c] = 0;
                m_busy[c] = 0;   m_pend[c]    = 0;
            end else begin
                if (cfg_valid && int'(cfg_channel) == c) begin
                    if (m_busy[c]) begin
                        m_sh_rate[c] = int'(cfg_rate); m_sh_mode[c] = cfg_mode; m_pend[c] = 1;
                    end else begin
                        m_rate[c] = int'(cfg_rate); m_mode[c] = cfg_mode;
                    end
                end
                if (stop[c] || start[c]) begin
                    if (m_pend[c]) begin
                        m_rate[c] = m_sh_rate[c]; m_mode[c] = m_sh_mode[c]; m_pend[c] = 0;
                    end
                    if (stop[c]) m_busy[c] = 0;
                    else begin
                        m_busy[c] = 1;
                        m_next[c] = n + m_rate[c] + 1;
                    end
                end else if (m_busy[c] && n == m_next[c]) begin
                    e_tick[c] = 1'b1;
                    old_mode  = m_mode[c];
                    if (m_pend[c]) begin
                        m_rate[c] = m_sh_rate[c]; m_mode[c] = m_sh_mode[c]; m_pend[c] = 0;
                    end
                    if (old_mode) m_busy[c] = 0;
                    else          m_next[c] = n + m_rate[c] + 1;
                end
            end
            e_busy[c] = m_busy[c];
            e_pend[c] = m_pend[c];
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < CH; c++) begin
            t_cnt[c]   = 0;
            t_first[c] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(tick), 32'(e_tick));
        check("busy", 32'(busy), 32'(e_busy));
        check("pending", 32'(pending), 32'(e_pend));
        for (int c = 0; c < CH; c++) begin
            if (tick[c]) begin
                t_cnt[c]++;
                if (t_first[c] < 0) t_first[c] = n;
            end
        end
        start = '0; stop = '0; cfg_valid = 1'b0;
        d3_start = '0; d3_stop = '0; d3_cfg_valid = 1'b0;
    endtask

    task automatic cfg(input int ch, input int rate, input bit mode);
        cfg_valid   = 1'b1;
        cfg_channel = 2'(ch);
        cfg_rate    = W'(rate);
        cfg_mode    = mode;
    endtask

    initial begin
        int n0;
        logic [2:0] seen;
        e_tick = '0; e_busy = '0; e_pend = '0;
        clear_stats();

        // Reset
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        check("rst_tick", 32'(tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);

        // ch0 periodic rate 3 written while idle
        cfg(0, 3, 0); step();
        start[0] = 1'b1; step(); n0 = n; clear_stats();
        repeat (12) step();
        check("ch0_first", t_first[0], n0 + 4);
        check("ch0_count", t_cnt[0], 3);
        check("ch0_busy", 32'(busy[0]), 1);

        // ch1 one-shot rate 5
        cfg(1, 5, 1); step();
        start[1] = 1'b1; step(); n0 = n; clear_stats();
        repeat (56) step();
        check("ch1_oneshot_count", t_cnt[1], 1);
        check("ch1_oneshot_first", t_first[1], n0 + 6);
        check("ch1_oneshot_busy", 32'(busy[1]), 0);

        // ch2 rate 9, reprogrammed to 2 mid-period
        cfg(2, 9, 0); step();
        start[2] = 1'b1; step(); n0 = n; clear_stats();
        repeat (3) step();
        cfg(2, 2, 0); step();
        check("ch2_pending_set", 32'(pending[2]), 1);
        repeat (16) step();
        check("ch2_first", t_first[2], n0 + 10);
        check("ch2_count", t_cnt[2], 4);
        check("ch2_pending_clr", 32'(pending[2]), 0);

        // ch3 rate 0, then start+stop together
        cfg(3, 0, 0); step();
        start[3] = 1'b1; step(); n0 = n; clear_stats();
        repeat (5) step();
        check("ch3_r0_count", t_cnt[3], 5);
        check("ch3_r0_first", t_first[3], n0 + 1);
        start[3] = 1'b1; stop[3] = 1'b1; step();
        check("ch3_startstop_busy", 32'(busy[3]), 0);
        check("ch3_startstop_tick", 32'(tick[3]), 0);

        // stop exactly on the wrap edge, rate 4
        cfg(3, 4, 0); step();
        start[3] = 1'b1; step();
        repeat (4) step();
        stop[3] = 1'b1; step();
        check("ch3_stopwrap_tick", 32'(tick[3]), 0);
        check("ch3_stopwrap_busy", 32'(busy[3]), 0);

        // reset mid-run, rates back to default
        resetn = 1'b0; step(); resetn = 1'b1;
        check("midrst_tick", 32'(tick), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_pending", 32'(pending), 0);
        start[0] = 1'b1; step(); n0 = n; clear_stats();
        repeat (14) step();
        check("default_rate_first", t_first[0], n0 + DEF + 1);

        // largest rate 2^W-1
        cfg(1, 255, 0); step();
        start[1] = 1'b1; step(); n0 = n; clear_stats();
        repeat (257) step();
        check("maxrate_first", t_first[1], n0 + 256);
        check("maxrate_count", t_cnt[1], 1);

        // out-of-range write on the three-channel instance
        d3_cfg_valid = 1'b1; d3_cfg_channel = 2'd3; d3_cfg_rate = '0; d3_cfg_mode = 1'b0;
        step();
        d3_start = 3'b111; step();
        seen = '0;
        repeat (12) begin
            step();
            seen |= d3_tick;
        end
        check("oor_no_early_tick", 32'(seen), 0);
        step();
        check("oor_default_tick", 32'(d3_tick), 32'h7);
        check("oor_busy", 32'(d3_busy), 32'h7);
        check("oor_pending", 32'(d3_pending), 0);

        // all channels at 1, 2, 3, 7 for 200 clocks
        stop = '1; step();
        cfg(0, 1, 0); step();
        cfg(1, 2, 0); step();
        cfg(2, 3, 0); step();
        cfg(3, 7, 0); step();
        start = '1; step(); clear_stats();
        repeat (200) step();
        check("all_cnt0", t_cnt[0], 100);
        check("all_cnt1", t_cnt[1], 66);
        check("all_cnt2", t_cnt[2], 50);
        check("all_cnt3", t_cnt[3], 25);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cfg_valid   = ($urandom_range(3) == 0);
            cfg_channel = 2'($urandom_range(3));
            cfg_rate    = ($urandom_range(15) == 0) ? W'($urandom_range(255)) : W'($urandom_range(6));
            cfg_mode    = 1'($urandom_range(1));
            for (int c = 0; c < CH; c++) begin
                start[c] = ($urandom_range(11) == 0);
                stop[c]  = ($urandom_range(23) == 0);
            end
            resetn = ($urandom_range(499) != 0);
            step();
        end
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
